// File: rtl/bus_host_arbiter.sv
// bus_host_arbiter: round-robin sharing of one device port between hosts, with in-order response routing
module bus_host_arbiter #(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddrWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NrHosts-1:0]                   host_req_i,
  output logic [NrHosts-1:0]                   host_gnt_o,
  input  logic [NrHosts-1:0][AddrWidth-1:0]    host_addr_i,
  input  logic [NrHosts-1:0]                   host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]  host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i,
  output logic [NrHosts-1:0]                   host_rvalid_o,
  output logic [DataWidth-1:0]                 host_rdata_o,
  output logic [NrHosts-1:0]                   host_err_o,
  output logic                                 dev_req_o,
  input  logic                                 dev_gnt_i,
  output logic [AddrWidth-1:0]                 dev_addr_o,
  output logic                                 dev_we_o,
  output logic [DataWidth/8-1:0]               dev_be_o,
  output logic [DataWidth-1:0]                 dev_wdata_o,
  input  logic                                 dev_rvalid_i,
  input  logic [DataWidth-1:0]                 dev_rdata_i,
  input  logic                                 dev_err_i
);
  localparam int HW = $clog2(NrHosts);
  localparam int PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam int CW = $clog2(MaxOutstanding + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [HW-1:0] rr_ptr, lock_id, winner, head;
  logic [HW-1:0] fifo [MaxOutstanding];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic full, empty, hs, pop, any_req;
  assign full    = count == CW'(MaxOutstanding);
  assign empty   = count == '0;
  assign head    = fifo[rptr];
  assign any_req = state_q == LOCKED || |host_req_i;
  // Scan from the highest offset down so the host nearest rr_ptr wins last.
  always_comb begin
    winner = state_q == LOCKED ? lock_id : rr_ptr;
    if (state_q == IDLE)
      for (int i = NrHosts - 1; i >= 0; i--)
        if (host_req_i[HW'((int'(rr_ptr) + i) % NrHosts)]) winner = HW'((int'(rr_ptr) + i) % NrHosts);
  end
  always_comb begin
    state_d = hs ? IDLE : dev_req_o ? LOCKED : state_q;
  end
  assign dev_req_o     = !rst_i && any_req && !full;
  assign hs            = dev_req_o && dev_gnt_i;
  assign pop           = !rst_i && dev_rvalid_i && !empty;
  assign host_gnt_o    = hs ? NrHosts'(1) << winner : '0;
  assign host_rvalid_o = pop ? NrHosts'(1) << head : '0;
  assign host_err_o    = pop && dev_err_i ? NrHosts'(1) << head : '0;
  assign host_rdata_o  = dev_rdata_i;
  assign dev_addr_o    = rst_i ? '0 : host_addr_i[winner];
  assign dev_we_o      = !rst_i && host_we_i[winner];
  assign dev_be_o      = rst_i ? '0 : host_be_i[winner];
  assign dev_wdata_o   = rst_i ? '0 : host_wdata_i[winner];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      if (dev_req_o && !dev_gnt_i) lock_id <= winner;
      if (hs) begin
        wptr   <= wptr == PW'(MaxOutstanding - 1) ? '0 : wptr + 1'b1;
        rr_ptr <= winner == HW'(NrHosts - 1) ? '0 : winner + 1'b1;
      end
      if (pop) rptr <= rptr == PW'(MaxOutstanding - 1) ? '0 : rptr + 1'b1;
      count <= count + CW'(hs) - CW'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (hs) fifo[wptr] <= winner;
  end
  assert property (@(posedge clk_i) disable iff (rst_i) state_q == LOCKED |-> host_req_i[lock_id])
    else $error("locked host dropped its request before grant");
  assert property (@(posedge clk_i) disable iff (rst_i) dev_rvalid_i |-> !empty)
    else $warning("dev_rvalid_i with no outstanding transaction was dropped");
endmodule

// File: tb/tb_bus_host_arbiter.sv
// tb_bus_host_arbiter: directed vector table, hand sequences and randomized run against a queue-based model
module tb_bus_host_arbiter;
  localparam int N = 2, DW = 32, AW = 32, MO = 2, BW = DW / 8;
  logic clk = 1'b0, rst;
  logic [N-1:0] host_req, host_gnt, host_we, host_rvalid, host_err;
  logic [N-1:0][AW-1:0] host_addr;
  logic [N-1:0][BW-1:0] host_be;
  logic [N-1:0][DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata, dev_rdata, dev_wdata;
  logic [AW-1:0] dev_addr;
  logic [BW-1:0] dev_be;
  logic dev_req, dev_gnt, dev_we, dev_rvalid, dev_err;
  int errors = 0, checks = 0;

  bus_host_arbiter #(.NrHosts(N), .DataWidth(DW), .AddrWidth(AW), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_i(rst), .host_req_i(host_req), .host_gnt_o(host_gnt),
    .host_addr_i(host_addr), .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
    .dev_be_o(dev_be), .dev_wdata_o(dev_wdata), .dev_rvalid_i(dev_rvalid),
    .dev_rdata_i(dev_rdata), .dev_err_i(dev_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst; logic [1:0] req; logic gnt, rv, err, e_req; logic [1:0] e_gnt, e_rv, e_err;
  } vec_t;
  vec_t tbl [19];

  // Called at posedge+1: drive, check at negedge, advance one clock.
  task automatic step(input vec_t v, input string tag);
    int w;
    rst = v.rst; host_req = v.req; dev_gnt = v.gnt; dev_rvalid = v.rv; dev_err = v.err;
    dev_rdata = $urandom;
    #4;
    w = v.e_gnt[1] ? 1 : 0;
    chk({tag, " dev_req"}, 64'(dev_req), 64'(v.e_req));
    chk({tag, " gnt"}, 64'(host_gnt), 64'(v.e_gnt));
    chk({tag, " rvalid"}, 64'(host_rvalid), 64'(v.e_rv));
    chk({tag, " err"}, 64'(host_err), 64'(v.e_err));
    if (v.e_gnt != 0) begin
      chk({tag, " addr"}, 64'(dev_addr), 64'(host_addr[w]));
      chk({tag, " we"}, 64'(dev_we), 64'(host_we[w]));
    end
    if (v.e_rv != 0) chk({tag, " rdata"}, 64'(host_rdata), 64'(dev_rdata));
    @(posedge clk); #1;
  endtask

  int q[$];
  int rr, lock, win;
  logic [N-1:0] pend;
  logic e_req;
  logic [N-1:0] e_gnt, e_rv, e_err;

  initial begin
    rst = 1'b1; host_req = '0; dev_gnt = 1'b0; dev_rvalid = 1'b0; dev_err = 1'b0; dev_rdata = '0;
    host_we = 2'b10;
    for (int h = 0; h < N; h++) begin
      host_addr[h] = 32'h1000 + 32'(h) * 32'h10;
      host_be[h] = 4'hf;
      host_wdata[h] = 32'hA000 + 32'(h);
    end
    tbl[0]  = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00};
    tbl[3]  = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b01, 2'b00};
    tbl[4]  = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 2'b10};
    tbl[5]  = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b01, 2'b00};
    tbl[6]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00};
    tbl[7]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00};
    tbl[8]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00};
    tbl[9]  = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
    tbl[10] = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
    tbl[13] = '{1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
    tbl[14] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10};
    tbl[15] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[16] = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00};
    tbl[17] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
    tbl[18] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    @(posedge clk); #1;
    for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("row%0d", i));
    // lock: first move rr_ptr to H0 so only the lock keeps H1 selected
    step('{1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00}, "lock_pre0");
    step('{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00}, "lock_pre1");
    step('{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00}, "lock_c1");
    step('{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00}, "lock_c2");
    chk("lock_c2 addr", 64'(dev_addr), 64'(host_addr[1]));
    step('{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00}, "lock_c3");
    chk("lock_c3 addr", 64'(dev_addr), 64'(host_addr[1]));
    step('{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00}, "lock_c4");
    step('{1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00}, "lock_c5");
    step('{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00}, "lock_d0");
    step('{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00}, "lock_d1");
    // reset with a transaction outstanding discards its ID
    step('{1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00}, "mrst0");
    step('{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00}, "mrst1");
    step('{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00}, "mrst2");
    step('{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00}, "mrst3");
    step('{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00}, "mrst4");
    // randomized run: model state is a plain ID queue, a priority index and a lock holder
    q = {}; rr = 0; lock = -1; pend = '0;
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 99) == 0;
      for (int h = 0; h < N; h++) begin
        if (!pend[h] && $urandom_range(0, 1) == 1) begin
          pend[h] = 1'b1;
          host_addr[h] = $urandom; host_we[h] = 1'($urandom); host_be[h] = 4'($urandom);
          host_wdata[h] = $urandom;
        end
      end
      host_req = pend;
      dev_gnt = $urandom_range(0, 2) != 0;
      dev_rvalid = q.size() > 0 && $urandom_range(0, 1) == 1;
      dev_err = 1'($urandom); dev_rdata = $urandom;
      #4;
      win = lock;
      if (lock < 0)
        for (int k = N - 1; k >= 0; k--) if (host_req[(rr + k) % N]) win = (rr + k) % N;
      e_req = !rst && (lock >= 0 || host_req != 0) && q.size() < MO;
      e_gnt = e_req && dev_gnt ? N'(1) << win : '0;
      e_rv = !rst && dev_rvalid && q.size() > 0 ? N'(1) << q[0] : '0;
      e_err = dev_err ? e_rv : '0;
      chk("rnd dev_req", 64'(dev_req), 64'(e_req));
      chk("rnd gnt", 64'(host_gnt), 64'(e_gnt));
      chk("rnd rvalid", 64'(host_rvalid), 64'(e_rv));
      chk("rnd err", 64'(host_err), 64'(e_err));
      if (e_rv != 0) chk("rnd rdata", 64'(host_rdata), 64'(dev_rdata));
      if (e_req) begin
        chk("rnd addr", 64'(dev_addr), 64'(host_addr[win]));
        chk("rnd we", 64'(dev_we), 64'(host_we[win]));
        chk("rnd be", 64'(dev_be), 64'(host_be[win]));
        chk("rnd wdata", 64'(dev_wdata), 64'(host_wdata[win]));
      end
      @(posedge clk); #1;
      if (rst) begin
        q = {}; rr = 0; lock = -1;
      end else begin
        if (e_rv != 0) void'(q.pop_front());
        if (e_gnt != 0) begin
          q.push_back(win); rr = (win + 1) % N; lock = -1; pend[win] = 1'b0;
        end else if (e_req) lock = win;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
